// File: rtl/mos_or2_switch.sv
// -----------------------------------------------------------------------------
// mos_or2_switch
//
// Cycle-based switch-level model of a six-transistor CMOS OR2 cell, used as a
// golden reference against gate-level OR2 results.
//
//   NOR stage : n1 (gate b), n2 (gate a) pull w5 to vss
//               p4 (gate a) vdd -> w6, p3 (gate b) w6 -> w5
//   Inverter  : n5 (gate w5) pulls y to vss, p6 (gate w5) pulls y to vdd
//
// Every transistor sees its gate through its own delay line of D_xx clock
// cycles. Node values are resolved combinationally from the delayed gates, so
// the delay-line registers are the only state. Transport delay is modelled:
// X/Z transients caused by unequal pull-up/pull-down delays are kept.
//
// 4-state encoding on every 2-bit value: 00=0, 01=1, 10=X, 11=Z.
//
// Parameters (delay in clock cycles, each >= 1):
//   D_N1, D_N2, D_P3, D_P4, D_N5, D_P6
//
// Ports:
//   clk  in   1  rising-edge clock
//   rst  in   1  asynchronous active-high reset, fills all delay lines with Z
//   a    in   2  4-state input A
//   b    in   2  4-state input B
//   y    out  2  4-state cell output
//   w5   out  2  internal NOR node (observation)
//   w6   out  2  series pull-up node between p4 and p3 (observation)
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// mos_or2_delay_line
//
// Gate-value delay line of STAGES registers. The output is the gate value
// sampled STAGES rising edges earlier. Reset loads Z into every stage, which
// makes the attached switch non-conducting-or-unknown until real values
// arrive.
//
// Ports:
//   clk       in   1  rising-edge clock
//   rst       in   1  asynchronous active-high reset
//   gate      in   2  undelayed gate node value
//   gate_dly  out  2  gate value seen by the transistor
// -----------------------------------------------------------------------------
module mos_or2_delay_line #(
    parameter int STAGES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] gate,
    output logic [1:0] gate_dly
);

    localparam logic [1:0] VZ = 2'b11;

    logic [1:0] taps [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                taps[i] <= VZ;
            end
        end else begin
            taps[0] <= gate;
            for (int i = 1; i < STAGES; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign gate_dly = taps[STAGES-1];

endmodule

module mos_or2_switch #(
    parameter int D_N1 = 3,
    parameter int D_N2 = 3,
    parameter int D_P3 = 3,
    parameter int D_P4 = 1,
    parameter int D_N5 = 2,
    parameter int D_P6 = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [1:0] y,
    output logic [1:0] w5,
    output logic [1:0] w6
);

    localparam logic [1:0] V0 = 2'b00;
    localparam logic [1:0] V1 = 2'b01;
    localparam logic [1:0] VX = 2'b10;
    localparam logic [1:0] VZ = 2'b11;

    localparam logic [1:0] VDD = V1;
    localparam logic [1:0] VSS = V0;

    // A switch whose gate is unknown still passes "nothing" when its source
    // is floating, so the unknown case only degrades a driven source to X.
    function automatic logic [1:0] unknown_drive(input logic [1:0] src);
        return (src == VZ) ? VZ : VX;
    endfunction

    function automatic logic [1:0] nmos_drive(input logic [1:0] g,
                                              input logic [1:0] src);
        logic [1:0] drv;
        case (g)
            V1:      drv = src;
            V0:      drv = VZ;
            default: drv = unknown_drive(src);
        endcase
        return drv;
    endfunction

    function automatic logic [1:0] pmos_drive(input logic [1:0] g,
                                              input logic [1:0] src);
        logic [1:0] drv;
        case (g)
            V0:      drv = src;
            V1:      drv = VZ;
            default: drv = unknown_drive(src);
        endcase
        return drv;
    endfunction

    // Pairwise wired resolution; Z is the identity, equal values merge and
    // any disagreement (including X against anything driven) gives X. The
    // rule is associative, so multi-driver nodes fold it pairwise.
    function automatic logic [1:0] resolve2(input logic [1:0] d0,
                                            input logic [1:0] d1);
        logic [1:0] res;
        if (d0 == VZ) begin
            res = d1;
        end else if (d1 == VZ) begin
            res = d0;
        end else if (d0 == d1) begin
            res = d0;
        end else begin
            res = VX;
        end
        return res;
    endfunction

    function automatic logic [1:0] resolve3(input logic [1:0] d0,
                                            input logic [1:0] d1,
                                            input logic [1:0] d2);
        return resolve2(resolve2(d0, d1), d2);
    endfunction

    // Delayed gate values as seen by each transistor.
    logic [1:0] g_n1;
    logic [1:0] g_n2;
    logic [1:0] g_p3;
    logic [1:0] g_p4;
    logic [1:0] g_n5;
    logic [1:0] g_p6;

    // Per-switch contributions onto their drain nodes.
    logic [1:0] drv_n1;
    logic [1:0] drv_n2;
    logic [1:0] drv_p3;
    logic [1:0] drv_p4;
    logic [1:0] drv_n5;
    logic [1:0] drv_p6;

    // ---- NOR stage gate delays (inputs a, b) ----
    mos_or2_delay_line #(.STAGES(D_N1)) u_dl_n1 (
        .clk      (clk),
        .rst      (rst),
        .gate     (b),
        .gate_dly (g_n1)
    );

    mos_or2_delay_line #(.STAGES(D_N2)) u_dl_n2 (
        .clk      (clk),
        .rst      (rst),
        .gate     (a),
        .gate_dly (g_n2)
    );

    mos_or2_delay_line #(.STAGES(D_P3)) u_dl_p3 (
        .clk      (clk),
        .rst      (rst),
        .gate     (b),
        .gate_dly (g_p3)
    );

    mos_or2_delay_line #(.STAGES(D_P4)) u_dl_p4 (
        .clk      (clk),
        .rst      (rst),
        .gate     (a),
        .gate_dly (g_p4)
    );

    // ---- NOR stage node resolution ----
    // w6 has a single driver (p4 from vdd); with no charge storage it floats
    // to Z whenever p4 is off.
    assign drv_p4 = pmos_drive(g_p4, VDD);
    assign w6     = drv_p4;

    // p3 forwards whatever w6 currently holds, so a floating w6 cannot pull
    // w5 up even when p3 is on.
    assign drv_n1 = nmos_drive(g_n1, VSS);
    assign drv_n2 = nmos_drive(g_n2, VSS);
    assign drv_p3 = pmos_drive(g_p3, w6);
    assign w5     = resolve3(drv_n1, drv_n2, drv_p3);

    // ---- Inverter gate delays (input w5) ----
    mos_or2_delay_line #(.STAGES(D_N5)) u_dl_n5 (
        .clk      (clk),
        .rst      (rst),
        .gate     (w5),
        .gate_dly (g_n5)
    );

    mos_or2_delay_line #(.STAGES(D_P6)) u_dl_p6 (
        .clk      (clk),
        .rst      (rst),
        .gate     (w5),
        .gate_dly (g_p6)
    );

    // ---- Inverter node resolution ----
    assign drv_n5 = nmos_drive(g_n5, VSS);
    assign drv_p6 = pmos_drive(g_p6, VDD);
    assign y      = resolve2(drv_n5, drv_p6);

endmodule

// File: tb/tb_mos_or2_switch.sv
// -----------------------------------------------------------------------------
// tb_mos_or2_switch
//
// Directed bench for mos_or2_switch with default delays. Outputs are sampled
// 1 time unit after each rising edge; inputs change at that same point so
// they are stable well before the next edge.
// -----------------------------------------------------------------------------
module tb_mos_or2_switch;

    localparam logic [1:0] L0 = 2'b00;
    localparam logic [1:0] L1 = 2'b01;
    localparam logic [1:0] LX = 2'b10;
    localparam logic [1:0] LZ = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] y;
    logic [1:0] w5;
    logic [1:0] w6;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mos_or2_switch dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .y   (y),
        .w5  (w5),
        .w6  (w6)
    );

    task automatic check_val(input string tag, input logic [1:0] got,
                             input logic [1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sweep expectations for (a,b) = 00, 01, 10, 11.
    logic [1:0] sweep_y  [4] = '{L0, L1, L1, L1};
    logic [1:0] sweep_w5 [4] = '{L1, L0, L0, L0};

    // Toggle phase (a period 4, b period 8, from settled a=0,b=0), hand
    // derived from the delay equations; index (k-1)%8 for w5/y, (k-1)%4 for w6.
    // y after edges 1 and 2 still reflects the old settled w5=1, i.e. 0.
    logic [1:0] tog_w5 [8] = '{LZ, LZ, L0, L0, L0, L0, LX, LX};
    logic [1:0] tog_y  [8] = '{LX, LX, LX, LX, L1, L1, L1, L1};
    logic [1:0] tog_w6 [4] = '{LZ, LZ, L1, L1};

    initial begin
        rst = 1'b1;
        a   = L0;
        b   = L0;
        step(1);
        check_val("rst_y",  y,  LX);
        check_val("rst_w5", w5, LX);
        check_val("rst_w6", w6, LX);
        rst = 1'b0;
        check_val("post_rst_y", y, LX);

        // Power-up with a=0, b=0.
        step(1);
        check_val("pu_e1_w6", w6, L1);
        check_val("pu_e1_w5", w5, LX);
        check_val("pu_e1_y",  y,  LX);
        step(1);
        check_val("pu_e2_w5", w5, LX);
        check_val("pu_e2_y",  y,  LX);
        step(1);
        check_val("pu_e3_w5", w5, L1);
        check_val("pu_e3_y",  y,  LX);
        step(1);
        check_val("pu_e4_y",  y,  LX);
        step(1);
        check_val("pu_e5_y",  y,  L0);
        step(3);

        // a 0 -> 1 from steady 00.
        a = L1;
        step(1);
        check_val("a01_e1_w6", w6, LZ);
        check_val("a01_e1_w5", w5, LZ);
        check_val("a01_e1_y",  y,  L0);
        step(1);
        check_val("a01_e2_w5", w5, LZ);
        check_val("a01_e2_y",  y,  L0);
        step(1);
        check_val("a01_e3_w5", w5, L0);
        check_val("a01_e3_y",  y,  LX);
        step(1);
        check_val("a01_e4_y",  y,  LX);
        step(1);
        check_val("a01_e5_y",  y,  L1);
        check_val("a01_e5_w5", w5, L0);
        check_val("a01_e5_w6", w6, LZ);

        // Static truth-table sweep.
        for (int i = 0; i < 4; i++) begin
            a = (i >= 2) ? L1 : L0;
            b = (i % 2 == 1) ? L1 : L0;
            step(8);
            check_val($sformatf("sweep%0d_y", i),  y,  sweep_y[i]);
            check_val($sformatf("sweep%0d_w5", i), w5, sweep_w5[i]);
        end

        // Unknown on a propagates to X.
        a = LX;
        b = L0;
        step(8);
        check_val("ax_w5", w5, LX);
        check_val("ax_w6", w6, LX);
        check_val("ax_y",  y,  LX);
        a = L1;
        step(8);
        check_val("ax_to1_y",  y,  L1);
        check_val("ax_to1_w5", w5, L0);

        // Reset in the middle of an a 0 -> 1 transition.
        a = L0;
        b = L0;
        step(8);
        a = L1;
        step(2);
        check_val("mid_pre_w5", w5, LZ);
        check_val("mid_pre_y",  y,  L0);
        rst = 1'b1;
        #1;
        check_val("mid_rst_w5", w5, LX);
        check_val("mid_rst_w6", w6, LX);
        check_val("mid_rst_y",  y,  LX);
        b = L1;
        step(1);
        check_val("mid_hold_y", y, LX);
        rst = 1'b0;
        step(4);
        check_val("mid_e4_y",  y,  LX);
        step(1);
        check_val("mid_e5_y",  y,  L1);
        check_val("mid_e5_w5", w5, L0);

        // Toggle a every 2 cycles and b every 4 cycles.
        a = L0;
        b = L0;
        step(8);
        for (int k = 1; k <= 32; k++) begin
            a = (((k - 1) / 2) % 2 == 0) ? L1 : L0;
            b = (((k - 1) / 4) % 2 == 0) ? L1 : L0;
            step(1);
            check_val($sformatf("tog%0d_w6", k), w6, tog_w6[(k - 1) % 4]);
            check_val($sformatf("tog%0d_w5", k), w5, tog_w5[(k - 1) % 8]);
            check_val($sformatf("tog%0d_y", k),  y,
                      (k <= 2) ? L0 : tog_y[(k - 1) % 8]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
